// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GROUP_W  : bit width of one lookahead group
//   MODE_*   : encodings of the sub input
//   pg_t     : one {propagate, generate} pair
//   pg_merge : combines an upper and a lower P/G pair into the pair of the
//              span they cover together
package cla_pkg;

    localparam int GROUP_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic pg_t pg_merge(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle of cla_adder_pipe.
//   Input side : in_valid, in_ready, a, b, c_in, sub
//   Output side: out_valid, out_ready, sum, c_out, ovf, zero
//   master     : the upstream/downstream agent around the adder
//   slave      : the adder itself
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );

endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
//   a, b  : group operand bits (b already conditioned for subtraction)
//   c_in  : carry into the group's LSB
//   s     : group sum bits
//   p, g  : group propagate / generate for the stage-level lookahead
//   c_out : carry out of the group's MSB
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c_in,
    output logic [GROUP_W-1:0] s,
    output logic               p,
    output logic               g,
    output logic               c_out
);

    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] c;
    pg_t                bit_pg [GROUP_W];
    pg_t                grp_pg;

    assign pb = a ^ b;
    assign gb = a & b;

    // Every internal carry is a flat sum of products of bit P/G and c_in.
    assign c[0] = c_in;
    assign c[1] = gb[0] | (pb[0] & c_in);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c_in);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & c_in);

    assign s = pb ^ c;

    always_comb begin
        for (int i = 0; i < GROUP_W; i++) begin
            bit_pg[i].p = pb[i];
            bit_pg[i].g = gb[i];
        end
    end

    // Balanced two-level merge tree for the group P/G.
    assign grp_pg = pg_merge(pg_merge(bit_pg[3], bit_pg[2]),
                             pg_merge(bit_pg[1], bit_pg[0]));

    assign p     = grp_pg.p;
    assign g     = grp_pg.g;
    assign c_out = grp_pg.g | (grp_pg.p & c_in);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : cla_adder_pipe_if slave port
//              in_valid/in_ready, a, b, c_in, sub  -> operand beat
//              out_valid/out_ready, sum, c_out, ovf, zero -> result beat
// The operation is A + B' + c' with B' = sub ? ~b : b, c' = sub ? ~c_in : c_in.
// The WIDTH/4 lookahead groups are split evenly over STAGES stages; stage k
// resolves its groups and passes carry, partial sum and operands onward.
// The whole pipe stalls as one unit whenever the output is held.
// WIDTH must be a multiple of 4 and STAGES must divide WIDTH/4.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    cla_adder_pipe_if.slave  bus
);

    localparam int GROUPS  = WIDTH / GROUP_W;
    localparam int GPS     = GROUPS / STAGES;
    localparam int STAGE_W = GPS * GROUP_W;

    logic adv;

    // Per-stage inputs: stage 0 from the port, stage k from register k-1.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] bx_in  [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             cry_in [STAGES];
    logic             vld_in [STAGES];

    // Per-stage combinational results.
    logic [WIDTH-1:0] sum_nx [STAGES];
    logic             cry_nx [STAGES];

    // Pipeline registers at the end of each stage.
    logic             vld_q  [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] bx_q   [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             cry_q  [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Global stall: everything moves only when the output slot is free.
    assign adv          = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.c_out     = cry_q[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        localparam int BASE = k * STAGE_W;

        logic [GPS-1:0]     gp;
        logic [GPS-1:0]     gg;
        logic [GPS-1:0]     gc;
        logic [GPS-1:0]     gco;
        logic [STAGE_W-1:0] s_grp;
        logic               unused_co;

        if (k == 0) begin : g_head
            assign a_in[k]   = bus.a;
            assign bx_in[k]  = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            assign cry_in[k] = (bus.sub == MODE_SUB) ? ~bus.c_in : bus.c_in;
            assign sum_in[k] = '0;
            assign vld_in[k] = bus.in_valid;
        end else begin : g_body
            assign a_in[k]   = a_q[k-1];
            assign bx_in[k]  = bx_q[k-1];
            assign cry_in[k] = cry_q[k-1];
            assign sum_in[k] = sum_q[k-1];
            assign vld_in[k] = vld_q[k-1];
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group4 u_grp (
                .a     (a_in[k][BASE + j*GROUP_W +: GROUP_W]),
                .b     (bx_in[k][BASE + j*GROUP_W +: GROUP_W]),
                .c_in  (gc[j]),
                .s     (s_grp[j*GROUP_W +: GROUP_W]),
                .p     (gp[j]),
                .g     (gg[j]),
                .c_out (gco[j])
            );
        end

        // Stage lookahead: carry into group j is the OR over i<j of
        // G[i] & P[i+1..j-1], plus c_in & P[0..j-1]; no group waits on
        // its neighbour's carry.
        always_comb begin
            logic acc;
            logic prod;
            acc   = 1'b0;
            prod  = 1'b0;
            gc    = '0;
            gc[0] = cry_in[k];
            for (int j = 1; j < GPS; j++) begin
                acc = cry_in[k];
                for (int m = 0; m < j; m++) begin
                    acc = acc & gp[m];
                end
                for (int i = 0; i < j; i++) begin
                    prod = gg[i];
                    for (int m = i + 1; m < j; m++) begin
                        prod = prod & gp[m];
                    end
                    acc = acc | prod;
                end
                gc[j] = acc;
            end
        end

        // Lower group carry-outs duplicate the lookahead carries above.
        assign unused_co = ^gco;

        always_comb begin
            sum_nx[k]                   = sum_in[k];
            sum_nx[k][BASE +: STAGE_W]  = s_grp;
        end

        assign cry_nx[k] = gco[GPS-1];

        // ---- stage k register boundary ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                cry_q[k] <= 1'b0;
            end else if (adv) begin
                vld_q[k] <= vld_in[k];
                sum_q[k] <= sum_nx[k];
                cry_q[k] <= cry_nx[k];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Operands still needed by the groups of later stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q[k]  <= '0;
                    bx_q[k] <= '0;
                end else if (adv) begin
                    a_q[k]  <= a_in[k];
                    bx_q[k] <= bx_in[k];
                end
            end
        end else begin : g_tail
            logic ovf_nx;
            logic zero_nx;

            // Signed overflow: operands agree in sign but the result does not.
            assign ovf_nx  = (a_in[k][WIDTH-1] == bx_in[k][WIDTH-1])
                          && (sum_nx[k][WIDTH-1] != a_in[k][WIDTH-1]);
            assign zero_nx = (sum_nx[k] == '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= ovf_nx;
                    zero_q <= zero_nx;
                end
            end
        end

    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe with WIDTH=16 at STAGES=2 (full plan),
// plus STAGES=1 and STAGES=4 copies fed the same accepted beats at full rate.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   lat_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_adder_pipe_if #(.WIDTH(16)) bus1 ();
    cla_adder_pipe_if #(.WIDTH(16)) bus2 ();
    cla_adder_pipe_if #(.WIDTH(16)) bus4 ();

    cla_adder_pipe #(.WIDTH(16), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    cla_adder_pipe #(.WIDTH(16), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    cla_adder_pipe #(.WIDTH(16), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus1.out_ready = 1'b1;
    assign bus4.out_ready = 1'b1;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          issued;
        bit          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q4[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic extra(input string nm, input logic [15:0] got);
        total++;
        bad++;
        $display("FAIL %s: unexpected result sum=%0h, none outstanding", nm, got);
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov, input logic z);
        exp_t e;
        e.sum = s; e.co = co; e.ov = ov; e.z = z; e.issued = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Reference: plain 17-bit addition for sum/carry, integer range test for overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [15:0] bp;
        logic [16:0] full;
        int          sa;
        int          sbv;
        int          r;
        bp   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {16'h0, (sb ? ~ci : ci)};
        sa   = int'($signed(a));
        sbv  = int'($signed(b));
        r    = sb ? (sa - sbv - int'(ci)) : (sa + sbv + int'(ci));
        e = mk(full[15:0], full[16], (r > 32767) || (r < -32768), full[15:0] == 16'h0);
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [15:0] s,
                         input logic co, input logic ov, input logic z, input int stages);
        chk({tag, ".sum"},  32'(s),  32'(e.sum));
        chk({tag, ".cout"}, 32'(co), 32'(e.co));
        chk({tag, ".ovf"},  32'(ov), 32'(e.ov));
        chk({tag, ".zero"}, 32'(z),  32'(e.z));
        if (e.lat) chk({tag, ".latency"}, 32'(cyc - e.issued), 32'(stages));
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            chk("s2.in_ready", 32'(bus2.in_ready), 32'(!(bus2.out_valid && !bus2.out_ready)));
            if (bus2.out_valid && bus2.out_ready) begin
                if (q2.size() == 0) extra("s2.out", bus2.sum);
                else begin
                    e = q2.pop_front();
                    score("s2", e, bus2.sum, bus2.c_out, bus2.ovf, bus2.zero, 2);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus1.out_valid) begin
            if (q1.size() == 0) extra("s1.out", bus1.sum);
            else begin
                e = q1.pop_front();
                score("s1", e, bus1.sum, bus1.c_out, bus1.ovf, bus1.zero, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus4.out_valid) begin
            if (q4.size() == 0) extra("s4.out", bus4.sum);
            else begin
                e = q4.pop_front();
                score("s4", e, bus4.sum, bus4.c_out, bus4.ovf, bus4.zero, 4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_valid(input logic v);
        bus1.in_valid = v;
        bus2.in_valid = v;
        bus4.in_valid = v;
    endtask

    // Presents one beat to all three DUTs; the STAGES=1/4 copies only see it
    // valid in the cycle the STAGES=2 copy accepts it, so all get the same beats.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input exp_t e);
        int n;
        @(posedge clk); #1;
        bus1.a = a; bus2.a = a; bus4.a = a;
        bus1.b = b; bus2.b = b; bus4.b = b;
        bus1.c_in = ci; bus2.c_in = ci; bus4.c_in = ci;
        bus1.sub = sb; bus2.sub = sb; bus4.sub = sb;
        bus2.in_valid = 1'b1;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        n = 0;
        while (!bus2.in_ready && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus2.in_ready) begin
            total++;
            bad++;
            $display("FAIL send.in_ready: got=0 want=1 after %0d cycles", n);
            bus2.in_valid = 1'b0;
        end else begin
            bus1.in_valid = 1'b1;
            bus4.in_valid = 1'b1;
            e.issued = cyc;
            e.lat    = lat_en;
            q2.push_back(e);
            e.lat    = 1'b1;
            q1.push_back(e);
            q4.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        set_valid(1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        set_valid(1'b0);
        rst = 1'b1;
        #1;
        chk("rst.out_valid", 32'(bus2.out_valid), 32'(0));
        chk("rst.sum",       32'(bus2.sum),       32'(0));
        chk("rst.cout",      32'(bus2.c_out),     32'(0));
        chk("rst.s4_valid",  32'(bus4.out_valid), 32'(0));
        q1.delete();
        q2.delete();
        q4.delete();
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(bus2.in_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        rst = 1'b1;
        set_valid(1'b0);
        bus1.a = '0; bus2.a = '0; bus4.a = '0;
        bus1.b = '0; bus2.b = '0; bus4.b = '0;
        bus1.c_in = 1'b0; bus2.c_in = 1'b0; bus4.c_in = 1'b0;
        bus1.sub = 1'b0; bus2.sub = 1'b0; bus4.sub = 1'b0;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("init.out_valid", 32'(bus2.out_valid), 32'(0));
        chk("init.sum",       32'(bus2.sum),       32'(0));
        chk("init.cout",      32'(bus2.c_out),     32'(0));
        chk("init.ovf",       32'(bus2.ovf),       32'(0));
        chk("init.zero",      32'(bus2.zero),      32'(0));
        rst = 1'b0;
        #1;
        chk("init.in_ready",  32'(bus2.in_ready),  32'(1));

        // Directed arithmetic vectors, hand-computed results.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0));
        idle();
        repeat (4) @(posedge clk);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        send(16'h0003, 16'h0005, 1'b1, 1'b1, mk(16'hFFFD, 1'b0, 1'b0, 1'b0));
        send(16'h0005, 16'h0005, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        send(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1));
        send(16'h0000, 16'h0000, 1'b1, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0));
        idle();
        repeat (8) @(posedge clk);

        // Backpressure: stall the output for 3 cycles once the first result shows.
        lat_en = 1'b0;
        #1;
        fork
            begin
                send(16'h0000, 16'h0001, 1'b0, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0));
                send(16'h0002, 16'h0003, 1'b0, 1'b0, mk(16'h0005, 1'b0, 1'b0, 1'b0));
                send(16'h0004, 16'h0005, 1'b0, 1'b0, mk(16'h0009, 1'b0, 1'b0, 1'b0));
                send(16'h0006, 16'h0007, 1'b0, 1'b0, mk(16'h000D, 1'b0, 1'b0, 1'b0));
                idle();
            end
            begin
                int n;
                n = 0;
                while (!bus2.out_valid && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("bp.first_valid", 32'(bus2.out_valid), 32'(1));
                bus2.out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    chk("bp.hold_sum",   32'(bus2.sum),       32'(16'h0001));
                    chk("bp.hold_valid", 32'(bus2.out_valid), 32'(1));
                    chk("bp.in_ready",   32'(bus2.in_ready),  32'(0));
                    @(posedge clk); #1;
                end
                bus2.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        lat_en = 1'b1;

        // Reset with two beats in flight; only the post-reset beat may appear.
        send(16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0, 1'b0));
        send(16'h0010, 16'h0020, 1'b0, 1'b0, mk(16'h0030, 1'b0, 1'b0, 1'b0));
        mid_reset();
        repeat (6) @(posedge clk);
        send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        idle();
        repeat (8) @(posedge clk);

        // Full-rate random stream, reference from the model.
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        idle();
        repeat (10) @(posedge clk);
        #1;

        chk("drain.s1", 32'(q1.size()), 32'(0));
        chk("drain.s2", 32'(q2.size()), 32'(0));
        chk("drain.s4", 32'(q4.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the team's 4-bit CLA to WIDTH bits, built from 4-bit lookahead groups. Group carries are registered between STAGES pipeline stages, and valid/ready handshakes sit on both sides. It sits in the datapath wherever a wide add/sub must meet timing.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
STAGES, 2, pipeline depth; must satisfy 1 <= STAGES <= WIDTH/4 and (WIDTH/4) % STAGES == 0.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat present.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry-in (add) or borrow-in (sub).
sub  input  1  0 = A+B+c_in; 1 = A-B-c_in.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result.
c_out  output  1  carry-out from the MSB of the internal addition (in sub mode, 1 = no borrow).
ovf  output  1  signed two's-complement overflow.
zero  output  1  sum == 0.

Behaviour:
- Reset: asynchronous, active-high on rst.
  - All stage valid bits clear.
  - sum, c_out, ovf, zero all read 0; out_valid = 0.
  - in_ready = 1 once rst deasserts.
- Arithmetic: internal operation is A + B' + c', where B' = sub ? ~b : b and c' = sub ? ~c_in : c_in.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - zero = (sum == 0), computed in the last stage.
- Partitioning: GROUPS = WIDTH/4 and GPS = GROUPS/STAGES.
  - Stage k (0-based) resolves groups k*GPS .. k*GPS+GPS-1.
  - Within a stage, group carries use lookahead across the stage's groups (group P/G), not ripple.
  - Between stages, register: the stage carry-out, the resolved sum bits, and the still-unresolved operand bits B' and A with their MSBs.
- Latency: exactly STAGES cycles from an accepted beat (in_valid && in_ready at edge t) to out_valid = 1 after edge t+STAGES-1, when there is no backpressure.
- Throughput: one beat per cycle.
- Handshake (global stall):
  - adv = !out_valid || out_ready; in_ready = adv.
  - When adv = 0, every stage register, including outputs, holds its value.
  - When adv = 1, all stages shift and the stage-0 valid loads in_valid.
  - Outputs stay stable while out_valid && !out_ready.
  - in_valid while in_ready = 0 is not accepted; the upstream holds its data.
- Bubbles propagate as invalid beats; they are not compacted.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Reset mid-operation discards all in-flight beats. The first output after reset comes from the first beat accepted after reset.
- STAGES = 1: a single registered stage; in_ready = !out_valid || out_ready.
- Simultaneous events: an output pop and an input accept in the same cycle are both allowed (adv = 1).

Decomposition:
- Shared package cla_pkg:
  - localparam GROUP_W = 4.
  - Mode constants MODE_ADD = 1'b0, MODE_SUB = 1'b1.
  - Group-P/G struct/typedef for each {p, g} pair.
- Sub-module cla_group4: combinational 4-bit lookahead group.
  - Inputs: a[3:0], b[3:0], c_in.
  - Outputs: s[3:0], group P, group G, c_out.
  - Instantiated GROUPS times.
- A small stage-level lookahead unit combines group P/G within a stage; it stays inline.

Test Plan:
All scenarios use WIDTH=16, STAGES=2.
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid=0 and sum=0 immediately; no stale result appears after release.
- Add: a=0x1234, b=0x4321, c_in=0, sub=0 -> sum=0x5555, c_out=0, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
- Wrap-around: a=0xFFFF, b=0x0001, add -> sum=0x0000, c_out=1, zero=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- Subtract: a=0x8000, b=0x0001, sub=1, c_in=0 -> sum=0x7FFF, c_out=1, ovf=1. Also a=0x0003, b=0x0005, sub=1, c_in=1 -> sum=0xFFFD, c_out=0.
- Backpressure: 4 back-to-back beats (0+1, 2+3, 4+5, 6+7) with out_ready low for 3 cycles once the first result is valid:
  - in_ready is low exactly while out_valid && !out_ready.
  - sum holds 0x0001 throughout the stall.
  - After release the outputs are 0x0001, 0x0005, 0x0009, 0x000D in order, none lost.
- Full-rate streaming: 100 random beats with in_valid=1 and out_ready=1 -> one result per cycle, all matching the reference model. Repeat with STAGES=1 and STAGES=4.
